scc_sram_arbiter: RTL and testbench

Time-slot scheduler that shares the single wave-table SRAM (5 waves A..E × 32 bytes) between the channel mixer's per-channel wave fetch and the CPU-side register block. It owns the 6-slot round (`slot` 0..5), grants the mixer one read per channel slot, and inserts CPU reads and writes into free slots. All SRAM strobes and return data are registered. It sits between the mixer, the register decoder and the wave SRAM inside the SCC core.

---
 rtl/scc_sram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_scc_sram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/scc_sram_arbiter.sv
// scc_sram_arbiter: time-slot scheduler that shares the wave-table SRAM
// (5 waves x 32 bytes) between the mixer's per-channel wave fetch and CPU
// register-block accesses. The round is NUM_CH mixer slots plus one CPU slot.
// Every SRAM strobe and every returned data byte is registered.
//
// Build option: SCC_ARB_IDLE_GRANT_EN
//   defined   - a pending CPU access may also use any channel slot the mixer
//               leaves idle (mix_req=0).
//   undefined - the CPU is served only in slot NUM_CH, so slot timing is fully
//               deterministic.
module scc_sram_arbiter #(
  parameter int NUM_CH = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [2:0] o_slot,
  input  logic       i_mix_req,
  input  logic [4:0] i_mix_a,
  output logic [7:0] o_mix_q,
  output logic       o_mix_q_en,
  input  logic       i_cpu_req,
  input  logic       i_cpu_we,
  input  logic [2:0] i_cpu_id,
  input  logic [4:0] i_cpu_a,
  input  logic [7:0] i_cpu_d,
  output logic       o_cpu_busy,
  output logic       o_cpu_ack,
  output logic [7:0] o_cpu_q,
  output logic [2:0] o_sram_id,
  output logic [4:0] o_sram_a,
  output logic [7:0] o_sram_d,
  output logic       o_sram_oe,
  output logic       o_sram_we,
  input  logic [7:0] i_sram_q
);

  localparam logic [2:0] CPU_SLOT  = 3'(NUM_CH);
  localparam logic [2:0] NUM_WAVES = 3'd5;

  logic [2:0] r_slot;
  logic       r_pend;
  logic       r_busy;
  logic       r_pend_we;
  logic [2:0] r_pend_id;
  logic [4:0] r_pend_a;
  logic [7:0] r_pend_d;

  logic       r_sram_oe;
  logic       r_sram_we;
  logic [2:0] r_sram_id;
  logic [4:0] r_sram_a;
  logic [7:0] r_sram_d;

  // Read pipeline tags: stage 1 is the strobe cycle, stage 2 the data cycle.
  logic       r_s1_mix, r_s1_cpu, r_s1_bad;
  logic       r_s2_mix, r_s2_cpu, r_s2_bad;

  logic       r_mix_q_en;
  logic [7:0] r_mix_q;
  logic       r_cpu_ack;
  logic [7:0] r_cpu_q;

  logic w_mix_gnt;
  logic w_cpu_slot_ok;
  logic w_cpu_gnt;
  logic w_cpu_bad;
  logic w_accept;

  assign w_mix_gnt = (r_slot < CPU_SLOT) && i_mix_req;
`ifdef SCC_ARB_IDLE_GRANT_EN
  assign w_cpu_slot_ok = (r_slot == CPU_SLOT) || !i_mix_req;
`else
  assign w_cpu_slot_ok = (r_slot == CPU_SLOT);
`endif
  // The mixer always owns its channel slot; the CPU only fills the remainder.
  assign w_cpu_gnt = r_pend && w_cpu_slot_ok && !w_mix_gnt;
  assign w_cpu_bad = (r_pend_id >= NUM_WAVES);
  assign w_accept  = i_cpu_req && !r_busy;

  // Free-running slot counter, 0..NUM_CH, never stalls.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_slot <= 3'd0;
    else if (r_slot == CPU_SLOT) r_slot <= 3'd0;
    else r_slot <= r_slot + 3'd1;
  end

  // CPU request latch and busy flag; busy drops in the ack cycle so a new
  // request can be accepted right then.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend    <= 1'b0;
      r_busy    <= 1'b0;
      r_pend_we <= 1'b0;
      r_pend_id <= 3'd0;
      r_pend_a  <= 5'd0;
      r_pend_d  <= 8'd0;
    end else if (w_accept) begin
      r_pend    <= 1'b1;
      r_busy    <= 1'b1;
      r_pend_we <= i_cpu_we;
      r_pend_id <= i_cpu_id;
      r_pend_a  <= i_cpu_a;
      r_pend_d  <= i_cpu_d;
    end else begin
      if (w_cpu_gnt) r_pend <= 1'b0;
      if ((w_cpu_gnt && r_pend_we) || r_s2_cpu) r_busy <= 1'b0;
    end
  end

  // SRAM strobes: at most one per cycle; address/data hold when idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sram_oe <= 1'b0;
      r_sram_we <= 1'b0;
      r_sram_id <= 3'd0;
      r_sram_a  <= 5'd0;
      r_sram_d  <= 8'd0;
    end else begin
      r_sram_oe <= 1'b0;
      r_sram_we <= 1'b0;
      if (w_mix_gnt) begin
        r_sram_oe <= 1'b1;
        r_sram_id <= r_slot;
        r_sram_a  <= i_mix_a;
      end else if (w_cpu_gnt && !w_cpu_bad) begin
        r_sram_id <= r_pend_id;
        r_sram_a  <= r_pend_a;
        if (r_pend_we) begin
          r_sram_we <= 1'b1;
          r_sram_d  <= r_pend_d;
        end else begin
          r_sram_oe <= 1'b1;
        end
      end
    end
  end

  // Read return pipeline and completion pulses; invalid-wave reads return FF.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_mix   <= 1'b0;
      r_s1_cpu   <= 1'b0;
      r_s1_bad   <= 1'b0;
      r_s2_mix   <= 1'b0;
      r_s2_cpu   <= 1'b0;
      r_s2_bad   <= 1'b0;
      r_mix_q_en <= 1'b0;
      r_mix_q    <= 8'd0;
      r_cpu_ack  <= 1'b0;
      r_cpu_q    <= 8'd0;
    end else begin
      r_s1_mix   <= w_mix_gnt;
      r_s1_cpu   <= w_cpu_gnt && !r_pend_we;
      r_s1_bad   <= w_cpu_bad;
      r_s2_mix   <= r_s1_mix;
      r_s2_cpu   <= r_s1_cpu;
      r_s2_bad   <= r_s1_bad;
      r_mix_q_en <= r_s2_mix;
      if (r_s2_mix) r_mix_q <= i_sram_q;
      r_cpu_ack  <= (w_cpu_gnt && r_pend_we) || r_s2_cpu;
      if (r_s2_cpu) r_cpu_q <= r_s2_bad ? 8'hFF : i_sram_q;
    end
  end

  assign o_slot     = r_slot;
  assign o_mix_q    = r_mix_q;
  assign o_mix_q_en = r_mix_q_en;
  assign o_cpu_busy = r_busy;
  assign o_cpu_ack  = r_cpu_ack;
  assign o_cpu_q    = r_cpu_q;
  assign o_sram_id  = r_sram_id;
  assign o_sram_a   = r_sram_a;
  assign o_sram_d   = r_sram_d;
  assign o_sram_oe  = r_sram_oe;
  assign o_sram_we  = r_sram_we;

endmodule

// File: tb/tb_scc_sram_arbiter.sv
// Bench for scc_sram_arbiter: randomized mixer/CPU traffic in phases of
// different mixer load, compared each cycle against a transaction-level
// model that schedules expected strobes and returns by absolute cycle.
module tb_scc_sram_arbiter;

  localparam int NCH  = 5;
  localparam int NCYC = 3000;

  logic       clk;
  logic       reset;
  logic [2:0] slot;
  logic       mix_req;
  logic [4:0] mix_a;
  logic [7:0] mix_q;
  logic       mix_q_en;
  logic       cpu_req;
  logic       cpu_we;
  logic [2:0] cpu_id;
  logic [4:0] cpu_a;
  logic [7:0] cpu_d;
  logic       cpu_busy;
  logic       cpu_ack;
  logic [7:0] cpu_q;
  logic [2:0] sram_id;
  logic [4:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_oe;
  logic       sram_we;
  logic [7:0] sram_q;

  scc_sram_arbiter #(.NUM_CH(NCH)) dut (
    .i_clk(clk), .i_reset(reset), .o_slot(slot),
    .i_mix_req(mix_req), .i_mix_a(mix_a), .o_mix_q(mix_q), .o_mix_q_en(mix_q_en),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_id(cpu_id), .i_cpu_a(cpu_a),
    .i_cpu_d(cpu_d), .o_cpu_busy(cpu_busy), .o_cpu_ack(cpu_ack), .o_cpu_q(cpu_q),
    .o_sram_id(sram_id), .o_sram_a(sram_a), .o_sram_d(sram_d),
    .o_sram_oe(sram_oe), .o_sram_we(sram_we), .i_sram_q(sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected events, indexed by absolute cycle.
  logic       exp_oe  [NCYC+8];
  logic       exp_we  [NCYC+8];
  logic [2:0] exp_id  [NCYC+8];
  logic [4:0] exp_a   [NCYC+8];
  logic [7:0] exp_d   [NCYC+8];
  logic       exp_mqen[NCYC+8];
  logic [7:0] exp_mq  [NCYC+8];
  logic       exp_ack [NCYC+8];
  logic       exp_cqv [NCYC+8];
  logic [7:0] exp_cq  [NCYC+8];
  logic       exp_rst [NCYC+8];
  logic [7:0] sq      [NCYC+8];

  // Model state: one outstanding CPU transaction and the round position.
  int         m_slot;
  bit         m_out;
  int         m_acc_c;
  int         m_ack_c;
  bit         m_we;
  logic [2:0] m_rid;
  logic [4:0] m_ra;
  logic [7:0] m_rd;
  logic [2:0] h_id;
  logic [4:0] h_a;
  logic [7:0] h_d, h_mq, h_cq;
  bit         prev_rd;

  initial begin
    bit busy, accept, pend_ok, mixg, cpug, bad;
    int phase, mix_pct;
    for (int i = 0; i < NCYC + 8; i++) begin
      exp_oe[i] = 0; exp_we[i] = 0; exp_id[i] = 0; exp_a[i] = 0; exp_d[i] = 0;
      exp_mqen[i] = 0; exp_mq[i] = 0; exp_ack[i] = 0; exp_cqv[i] = 0;
      exp_cq[i] = 0; exp_rst[i] = 0; sq[i] = 8'($urandom_range(0, 255));
    end
    m_slot = 0; m_out = 0; m_acc_c = 0; m_ack_c = -1; m_we = 0;
    m_rid = 0; m_ra = 0; m_rd = 0;
    h_id = 0; h_a = 0; h_d = 0; h_mq = 0; h_cq = 0; prev_rd = 0;
    reset = 1; mix_req = 0; mix_a = 0; cpu_req = 0; cpu_we = 0;
    cpu_id = 0; cpu_a = 0; cpu_d = 0; sram_q = 0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (exp_rst[cyc]) begin
        h_id = 0; h_a = 0; h_d = 0; h_mq = 0; h_cq = 0;
      end
      if (exp_oe[cyc] || exp_we[cyc]) begin h_id = exp_id[cyc]; h_a = exp_a[cyc]; end
      if (exp_we[cyc])   h_d  = exp_d[cyc];
      if (exp_mqen[cyc]) h_mq = exp_mq[cyc];
      if (exp_cqv[cyc])  h_cq = exp_cq[cyc];
      if (m_out && m_ack_c == cyc) m_out = 0;
      busy = m_out && (cyc > m_acc_c) && (m_ack_c < 0 || cyc < m_ack_c);

      if (cyc >= 1) begin
        check("slot",     32'(slot),     32'(m_slot));
        check("sram_oe",  32'(sram_oe),  32'(exp_oe[cyc]));
        check("sram_we",  32'(sram_we),  32'(exp_we[cyc]));
        check("sram_id",  32'(sram_id),  32'(h_id));
        check("sram_a",   32'(sram_a),   32'(h_a));
        check("sram_d",   32'(sram_d),   32'(h_d));
        check("mix_q_en", 32'(mix_q_en), 32'(exp_mqen[cyc]));
        check("mix_q",    32'(mix_q),    32'(h_mq));
        check("cpu_ack",  32'(cpu_ack),  32'(exp_ack[cyc]));
        check("cpu_q",    32'(cpu_q),    32'(h_cq));
        check("cpu_busy", 32'(cpu_busy), 32'(busy));
      end

      // Stimulus for this cycle; each phase uses a different mixer load.
      phase = cyc / 600;
      case (phase)
        0: mix_pct = 100;
        1: mix_pct = 0;
        2: mix_pct = 50;
        3: mix_pct = 80;
        default: mix_pct = 30;
      endcase
      mix_req = ($urandom_range(0, 99) < mix_pct);
      mix_a   = 5'($urandom_range(0, 31));
      cpu_req = ($urandom_range(0, 99) < 30);
      cpu_we  = 1'($urandom_range(0, 1));
      cpu_id  = 3'($urandom_range(0, 7));
      cpu_a   = 5'($urandom_range(0, 31));
      cpu_d   = 8'($urandom_range(0, 255));
      sram_q  = sq[cyc];
      reset   = (cyc < 2) || ($urandom_range(0, 399) == 0) ||
                (phase == 3 && prev_rd && $urandom_range(0, 1) == 1);

      // Reference model for this cycle.
      if (reset) begin
        for (int k = 1; k <= 3; k++) begin
          exp_oe[cyc+k] = 0; exp_we[cyc+k] = 0; exp_mqen[cyc+k] = 0;
          exp_ack[cyc+k] = 0; exp_cqv[cyc+k] = 0;
        end
        exp_rst[cyc+1] = 1;
        m_out = 0; m_ack_c = -1; prev_rd = 0;
        m_slot = 0;
      end else begin
        accept  = cpu_req && !busy;
        pend_ok = m_out && (m_ack_c < 0) && (cyc > m_acc_c);
        mixg    = (m_slot < NCH) && mix_req;
`ifdef SCC_ARB_IDLE_GRANT_EN
        cpug    = pend_ok && !mixg;
`else
        cpug    = pend_ok && (m_slot == NCH);
`endif
        if (mixg) begin
          exp_oe[cyc+1]   = 1;
          exp_id[cyc+1]   = 3'(m_slot);
          exp_a[cyc+1]    = mix_a;
          exp_mqen[cyc+3] = 1;
          exp_mq[cyc+3]   = sq[cyc+2];
        end
        prev_rd = 0;
        if (cpug) begin
          bad = (m_rid >= 3'd5);
          if (m_we) begin
            exp_we[cyc+1]  = !bad;
            exp_id[cyc+1]  = m_rid;
            exp_a[cyc+1]   = m_ra;
            exp_d[cyc+1]   = m_rd;
            exp_ack[cyc+1] = 1;
            m_ack_c = cyc + 1;
          end else begin
            exp_oe[cyc+1]  = !bad;
            exp_id[cyc+1]  = m_rid;
            exp_a[cyc+1]   = m_ra;
            exp_ack[cyc+3] = 1;
            exp_cqv[cyc+3] = 1;
            exp_cq[cyc+3]  = bad ? 8'hFF : sq[cyc+2];
            m_ack_c = cyc + 3;
            prev_rd = 1;
          end
        end
        if (accept) begin
          m_out = 1; m_acc_c = cyc; m_ack_c = -1;
          m_we = cpu_we; m_rid = cpu_id; m_ra = cpu_a; m_rd = cpu_d;
        end
        m_slot = (m_slot == NCH) ? 0 : m_slot + 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
